// File: rtl/max1452_pkg.sv
// max1452_pkg: shared FSM encoding and MAX1452 command bytes for the config sequencer
package max1452_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;
    localparam logic [7:0] CMD_WRITE = 8'h09;
    localparam logic [7:0] CMD_TERM  = 8'hfa;
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 LSB-first serializer, one byte per load, tx driven from a flop
module uart_tx_byte #(
    parameter int CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       clr,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);
    localparam int CW = $clog2(CLK_DIV);
    logic          active;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [8:0]    sh;
    logic          last_tick;
    assign last_tick = cnt == CW'(CLK_DIV - 1);
    assign ready = !active || (bit_idx == 4'd9 && last_tick);
    // bit timer reloads at every boundary; shifter carries the stop bit in sh[8]
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '1;
            tx      <= 1'b1;
        end else if (clr) begin
            active  <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
        end else if (load) begin
            active  <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= {1'b1, data};
            tx      <= 1'b0;
        end else if (active) begin
            if (last_tick) begin
                cnt <= '0;
                if (bit_idx == 4'd9) begin
                    active  <= 1'b0;
                    bit_idx <= '0;
                    tx      <= 1'b1;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    tx      <= sh[0];
                    sh      <= {1'b1, sh[8:1]};
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/max1452_cfg_seq.sv
// max1452_cfg_seq: sends a table of bytes over UART while holding the MAX1452 UNLOCK pin low
module max1452_cfg_seq
    import max1452_pkg::*;
#(
    parameter int CLK_DIV     = 434,
    parameter int DEPTH       = 32,
    parameter int UNLOCK_HOLD = 16,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW:0]   len,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   byte_cnt,
    output logic          rs_tx,
    output logic          unlock
);
    localparam int HW = $clog2(UNLOCK_HOLD + 1);
    logic [1:0]    state, nxt;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_addr;
    logic [AW:0]   len_q;
    logic [HW-1:0] hold_cnt;
    logic          ready, len_ok, go, hold_last, last_byte;
    assign len_ok    = len != '0 && len <= (AW+1)'(DEPTH);
    assign go        = state == ST_IDLE && start && !abort && len_ok;
    assign hold_last = hold_cnt == HW'(UNLOCK_HOLD - 1);
    assign last_byte = byte_cnt + (AW+1)'(1) == len_q;
    // next state; abort from any busy state drops straight back to idle
    always_comb begin
        nxt = abort              ? ST_IDLE :
              state == ST_IDLE   ? (go ? ST_FETCH : ST_IDLE) :
              state == ST_FETCH  ? ST_SEND :
              state == ST_SEND   ? (ready ? (last_byte ? ST_HOLD : ST_FETCH) : ST_SEND) :
              hold_last          ? ST_IDLE : ST_HOLD;
    end
    // sequencer registers; busy/unlock derive from the next state so they are flop outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            unlock   <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            byte_cnt <= '0;
            rd_addr  <= '0;
            len_q    <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= nxt;
            busy     <= nxt != ST_IDLE;
            unlock   <= nxt == ST_IDLE;
            done     <= state == ST_HOLD && hold_last && !abort;
            err      <= state == ST_IDLE && start && !abort && !len_ok;
            hold_cnt <= state == ST_HOLD ? hold_cnt + HW'(1) : '0;
            if (go) begin
                len_q    <= len;
                rd_addr  <= '0;
                byte_cnt <= '0;
            end
            if (state == ST_SEND && ready && !abort) begin
                byte_cnt <= byte_cnt + (AW+1)'(1);
                if (!last_byte)
                    rd_addr <= rd_addr + AW'(1);
            end
        end
    end
    // byte table, writable only while idle and never reset
    always_ff @(posedge clk) begin
        if (wr_en && state == ST_IDLE)
            mem[wr_addr] <= wr_data;
    end
    uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state == ST_FETCH && !abort),
        .clr   (abort),
        .data  (mem[rd_addr]),
        .ready (ready),
        .tx    (rs_tx)
    );
endmodule

// File: tb/tb_max1452_cfg_seq.sv
// tb_max1452_cfg_seq: random table sequences checked cycle by cycle against a waveform model
module tb_max1452_cfg_seq;
    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 8;
    localparam int UH      = 3;
    localparam int AW      = 3;
    localparam int FRAME   = 1 + 10 * CLK_DIV;

    typedef struct packed {
        logic tx;
        logic unl;
        logic bsy;
        logic dn;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic [AW:0]   len = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          busy, done, err, rs_tx, unlock;
    logic [AW:0]   byte_cnt;

    logic [7:0] tbl [DEPTH];
    exp_t       exp_q [$];
    int         checks = 0;
    int         errors = 0;

    max1452_cfg_seq #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH), .UNLOCK_HOLD(UH)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len(len), .start(start), .abort(abort), .busy(busy), .done(done), .err(err),
        .byte_cnt(byte_cnt), .rs_tx(rs_tx), .unlock(unlock)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        wr_en = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        tbl[a] = d;
    endtask

    task automatic fill_random();
        for (int a = 0; a < DEPTH; a++) wr(a, 8'($urandom));
    endtask

    // expected line levels for each cycle after the accepting edge
    function automatic void build(input int n);
        logic v;
        exp_q.delete();
        for (int b = 0; b < n; b++) begin
            exp_q.push_back('{1'b1, 1'b0, 1'b1, 1'b0});
            for (int k = 0; k < 10; k++) begin
                v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : tbl[b][k-1];
                repeat (CLK_DIV) exp_q.push_back('{v, 1'b0, 1'b1, 1'b0});
            end
        end
        repeat (UH) exp_q.push_back('{1'b1, 1'b0, 1'b1, 1'b0});
        exp_q.push_back('{1'b1, 1'b1, 1'b0, 1'b1});
    endfunction

    task automatic cmp(input string tag, input exp_t e);
        check({tag, "_tx"}, rs_tx, e.tx);
        check({tag, "_unlock"}, unlock, e.unl);
        check({tag, "_busy"}, busy, e.bsy);
        check({tag, "_done"}, done, e.dn);
        check({tag, "_err"}, err, 1'b0);
    endtask

    // ab/itf/rs: index at which to abort, interfere, or reset (-1 = never)
    task automatic run(input int n, input int ab, input int itf, input int rs);
        bit stop = 0;
        build(n);
        start = 1'b1;
        len = (AW+1)'(n);
        for (int i = 0; i < exp_q.size() && !stop; i++) begin
            @(negedge clk);
            start = 1'b0;
            wr_en = 1'b0;
            cmp("seq", exp_q[i]);
            if (i == itf) begin
                wr_en = 1'b1;
                wr_addr = '0;
                wr_data = ~tbl[0];
                start = 1'b1;
                len = 1;
            end
            if (i == ab) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                cmp("abort", '{1'b1, 1'b1, 1'b0, 1'b0});
                check("abort_byte_cnt", byte_cnt, i / FRAME);
                repeat (8) begin
                    @(negedge clk);
                    check("abort_no_done", done, 1'b0);
                end
                stop = 1;
            end
            if (i == rs) begin
                rst_n = 1'b0;
                #1;
                check("rst_tx", rs_tx, 1'b1);
                check("rst_unlock", unlock, 1'b1);
                check("rst_busy", busy, 1'b0);
                #2 rst_n = 1'b1;
                @(negedge clk);
                cmp("post_rst", '{1'b1, 1'b1, 1'b0, 1'b0});
                stop = 1;
            end
        end
        if (ab < 0 && rs < 0) check("byte_cnt", byte_cnt, n);
        @(negedge clk);
    endtask

    task automatic reject(input int l, input logic ab);
        start = 1'b1;
        abort = ab;
        len = (AW+1)'(l);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("rej_err", err, !ab);
        check("rej_busy", busy, 1'b0);
        check("rej_tx", rs_tx, 1'b1);
        @(negedge clk);
        check("rej_err_clear", err, 1'b0);
        check("rej_busy2", busy, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        check("reset_tx", rs_tx, 1'b1);
        check("reset_unlock", unlock, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_err", err, 1'b0);
        check("reset_byte_cnt", byte_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        wr(0, 8'h01);
        wr(1, 8'hf0);
        wr(2, 8'h11);
        run(3, -1, -1, -1);
        wr(0, 8'hA5);
        run(1, -1, -1, -1);
        reject(0, 1'b0);
        reject(DEPTH + 1, 1'b0);
        reject(2, 1'b1);
        reject(0, 1'b1);
        for (int r = 0; r < 4; r++) begin
            fill_random();
            run($urandom_range(1, DEPTH), -1, -1, -1);
        end
        fill_random();
        run(DEPTH, -1, -1, -1);
        fill_random();
        run(4, FRAME + 1 + $urandom_range(0, 10 * CLK_DIV - 1), -1, -1);
        run(4, 0, -1, -1);
        fill_random();
        run(2, -1, 10, -1);
        run(2, -1, -1, -1);
        run(2, -1, -1, 1 + $urandom_range(0, CLK_DIV - 1));
        check("after_rst_byte_cnt", byte_cnt, 0);
        run(3, -1, -1, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/max1452_cfg_seq.md
MAX1452_CFG_SEQ -- requirements
Module: max1452_cfg_seq

Interface
REQ-001 Parameter CLK_DIV, default 434, clocks per UART bit (legal range 2 to 65535).
REQ-002 Parameter DEPTH, default 32, number of entries in the byte table (power of two, 2 to 256).
REQ-003 Parameter UNLOCK_HOLD, default 16, clocks that unlock stays low after the last stop bit.
REQ-004 Derived constant AW = clog2(DEPTH).
REQ-005 Port clk, input, 1, clock.
REQ-006 Port rst_n, input, 1, reset: asynchronous, active-low.
REQ-007 Port wr_en, input, 1, table write strobe.
REQ-008 Port wr_addr, input, AW, table write address.
REQ-009 Port wr_data, input, 8, table write data.
REQ-010 Port len, input, AW+1, number of bytes to send; sampled on an accepted start.
REQ-011 Port start, input, 1, single-cycle request to send a sequence.
REQ-012 Port abort, input, 1, terminates the sequence in progress.
REQ-013 Port busy, output, 1, high while not IDLE.
REQ-014 Port done, output, 1, one-cycle pulse on normal completion.
REQ-015 Port err, output, 1, one-cycle pulse when a start is rejected.
REQ-016 Port byte_cnt, output, AW+1, number of bytes fully sent in the current or last sequence.
REQ-017 Port rs_tx, output, 1, UART serial line: 8N1, LSB first, idle high.
REQ-018 Port unlock, output, 1, MAX1452 UNLOCK pin drive.

Function
REQ-019 FSM states: IDLE, FETCH, SEND, HOLD.
REQ-020 Table writes are accepted only in IDLE.
- A write during busy is dropped.
- The table is synchronous with a 1-cycle read.
REQ-021 Start acceptance in IDLE:
- Accepted when 1 <= len <= DEPTH.
- On acceptance: len is latched, the read address is cleared, byte_cnt is cleared, and the FSM goes to FETCH.
- Otherwise err pulses the next cycle and the FSM stays in IDLE.
REQ-022 A start outside IDLE is ignored, with no err.
REQ-023 FETCH lasts exactly 1 clock; rs_tx is high.
- The table entry at the read address is registered into the shift register.
- The FSM then goes to SEND.
REQ-024 SEND frame, each bit exactly CLK_DIV clocks: start bit 0, data bits 0..7, stop bit 1.
REQ-025 After the last clock of the stop bit:
- byte_cnt increments.
- If byte_cnt then equals the latched len, the FSM goes to HOLD.
- Otherwise the read address increments and the FSM goes to FETCH.
- Result: exactly 1 idle-high clock between frames.
REQ-026 HOLD lasts UNLOCK_HOLD clocks with rs_tx high, then returns to IDLE with done pulsing for 1 cycle.
REQ-027 unlock is high in IDLE and low in FETCH, SEND and HOLD.
- It is registered: low from the first cycle after start acceptance, and high again in the same cycle done is high.
REQ-028 Abort in any non-IDLE state: the next cycle the FSM is in IDLE, rs_tx is high and unlock is high.
- No done pulse.
- byte_cnt keeps its value.
REQ-029 Simultaneous start and abort in IDLE: abort wins, start is ignored, no err.
REQ-030 rs_tx, unlock, busy, done and err are driven directly from flops (glitch-free).
REQ-031 The bit-period counter is wide enough for CLK_DIV-1.
- It reloads at each bit boundary with no cumulative drift.

Reset
REQ-032 Reset values:
- FSM in IDLE.
- rs_tx = 1, unlock = 1.
- busy, done and err = 0.
- byte_cnt = 0.
- Bit counter and bit index = 0.
REQ-033 Reset mid-frame returns rs_tx high asynchronously; the frame is not completed.
REQ-034 Table contents are not reset; they are undefined until written.

Structure
REQ-035 A shared package max1452_pkg holds:
- The FSM state encoding.
- The MAX1452 command-byte constants (e.g. 8'h09 write, 8'hfa terminate).
REQ-036 The UART serializer is the sub-module uart_tx_byte (ports: load, data, ready, tx), parametrised by CLK_DIV.
- The sequencer, table and unlock logic stay in max1452_cfg_seq.

Verification
REQ-037 Sequence of 3 bytes (CLK_DIV=4, UNLOCK_HOLD=3): write 01/f0/11, start len=3 ->
- rs_tx shows 3 frames of 40 clocks each, separated by a 1-clock gap.
- done pulses 3 clocks after the last stop bit.
- byte_cnt = 3.
- unlock is low for the entire interval.
REQ-038 Bit order: byte 8'hA5 -> data bits observed 1,0,1,0,0,1,0,1, with start bit 0 and stop bit 1.
REQ-039 Rejected starts: len=0 or len=DEPTH+1 -> err pulse, busy stays 0, rs_tx stays high.
REQ-040 Abort mid-byte 2 of 4 -> the next cycle is IDLE with rs_tx=1 and unlock=1, byte_cnt=1, no done.
REQ-041 Interference:
- A write during busy does not change the table (the resend sends the original data).
- A start during busy is ignored.
REQ-042 Async reset asserted mid-frame -> rs_tx=1 and unlock=1 immediately.
- After release, the FSM is in IDLE.
